bus_arbiter: RTL and testbench

- Round-robin arbiter that shares the common 4-bit data bus between N tri-state drivers.
- Generates one-hot, registered enables; each bit drives the enable of one 4-bit tri-state buffer instance.
- Enforces a dead (all-Z) turnaround gap between owners so two drivers never contend.
- Sits between requesting units (register file, ALU output, input port, ...) and their bus buffers.

---
 rtl/bus_pkg.sv | 17 +
 rtl/rr_picker.sv | 37 +++
 rtl/bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_bus_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus arbitration blocks.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_e;

    localparam int BUS_W = 4;

    // Index width for n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after last_owner, with wrap.
module rr_picker
    import bus_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_owner,
    output logic [IW-1:0]    winner,
    output logic             any_req
);

    logic [IW-1:0] cand_s;
    logic          found_s;
    int            idx_s;

    // Scan from last_owner+1 upward; the first hit wins, later hits are ignored.
    always_comb begin
        winner  = '0;
        found_s = 1'b0;
        cand_s  = '0;
        idx_s   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx_s  = (int'(last_owner) + k) % N_REQ;
            cand_s = IW'(idx_s);
            if (!found_s && req[cand_s]) begin
                winner  = cand_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner selection for the shared tri-state bus, with a
// guaranteed all-Z turnaround gap between successive owners.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int MAX_HOLD    = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         grant,
    output logic [idx_w(N_REQ)-1:0]  owner,
    output logic                     busy
);

    localparam int IW = idx_w(N_REQ);
    localparam int HW = idx_w(MAX_HOLD + 1);
    localparam int TW = idx_w(TURN_CYCLES + 1);

    if (TURN_CYCLES < 1) begin : g_bad_turn
        $error("bus_arbiter: TURN_CYCLES must be at least 1");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("bus_arbiter: N_REQ must be in 2..8");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("bus_arbiter: MAX_HOLD must be at least 1");
    end

    state_e             state_r, state_s;
    logic [N_REQ-1:0]   grant_r, grant_s;
    logic [IW-1:0]      owner_r, owner_s;
    logic               busy_r, busy_s;
    logic [HW-1:0]      hold_cnt_r, hold_cnt_s;
    logic [TW-1:0]      turn_cnt_r, turn_cnt_s;
    logic [IW-1:0]      last_owner_r, last_owner_s;
    logic [IW-1:0]      winner_s;
    logic               any_req_s;
    logic               others_s;

    rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
        .req        (req),
        .last_owner (last_owner_r),
        .winner     (winner_s),
        .any_req    (any_req_s)
    );

    assign others_s = |(req & ~grant_r);

    // State and output registers; reset floats every buffer without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            owner_r      <= '0;
            busy_r       <= 1'b0;
            hold_cnt_r   <= '0;
            turn_cnt_r   <= '0;
            last_owner_r <= IW'(N_REQ - 1);
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            owner_r      <= owner_s;
            busy_r       <= busy_s;
            hold_cnt_r   <= hold_cnt_s;
            turn_cnt_r   <= turn_cnt_s;
            last_owner_r <= last_owner_s;
        end
    end

    // Next-state logic; every path out of GRANT passes through TURN with grant=0.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        owner_s      = owner_r;
        busy_s       = busy_r;
        hold_cnt_s   = hold_cnt_r;
        turn_cnt_s   = turn_cnt_r;
        last_owner_s = last_owner_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_s           = GRANT;
                    grant_s           = '0;
                    grant_s[winner_s] = 1'b1;
                    owner_s           = winner_s;
                    busy_s            = 1'b1;
                    last_owner_s      = winner_s;
                    hold_cnt_s        = HW'(1);
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                if (!req[owner_r] || (hold_cnt_r == HW'(MAX_HOLD) && others_s)) begin
                    state_s    = TURN;
                    grant_s    = '0;
                    owner_s    = '0;
                    busy_s     = 1'b0;
                    hold_cnt_s = '0;
                    turn_cnt_s = TW'(1);
                end else if (hold_cnt_r == HW'(MAX_HOLD)) begin
                    hold_cnt_s = HW'(1);
                end else begin
                    hold_cnt_s = hold_cnt_r + HW'(1);
                end
            end
            TURN: begin
                if (turn_cnt_r == TW'(TURN_CYCLES)) begin
                    turn_cnt_s = '0;
                    if (any_req_s) begin
                        state_s           = GRANT;
                        grant_s           = '0;
                        grant_s[winner_s] = 1'b1;
                        owner_s           = winner_s;
                        busy_s            = 1'b1;
                        last_owner_s      = winner_s;
                        hold_cnt_s        = HW'(1);
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    turn_cnt_s = turn_cnt_r + TW'(1);
                end
            end
            default: begin
                state_s    = IDLE;
                grant_s    = '0;
                owner_s    = '0;
                busy_s     = 1'b0;
                hold_cnt_s = '0;
                turn_cnt_s = '0;
            end
        endcase
    end

    assign grant = grant_r;
    assign owner = owner_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized self-checking bench for bus_arbiter (N_REQ=4,
// MAX_HOLD=8, TURN_CYCLES=1).
module tb_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;

    int checks;
    int errors;

    bus_arbiter #(.N_REQ(4), .MAX_HOLD(8), .TURN_CYCLES(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant),
        .owner (owner),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_grant;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [1:0] oh2idx(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic check_out(input logic [3:0] eg, input string name);
        checks++;
        if (grant !== eg || busy !== (eg != 4'd0) || owner !== oh2idx(eg)) begin
            errors++;
            $display("FAIL %s: grant=%b busy=%b owner=%0d, required grant=%b busy=%b owner=%0d",
                     name, grant, busy, owner, eg, (eg != 4'd0), oh2idx(eg));
        end
    endtask

    // Drive req, let one rising edge sample it, check just after the edge.
    task automatic cyc(input logic [3:0] r, input logic [3:0] eg, input string name);
        req = r;
        @(posedge clk);
        #1;
        check_out(eg, name);
    endtask

    logic [3:0] prev_g;
    logic [3:0] last_nz;
    int         zero_run;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 4'd0;

        vecs[0]  = '{4'b0000, 4'b0000};
        vecs[1]  = '{4'b0001, 4'b0001};
        vecs[2]  = '{4'b0001, 4'b0001};
        vecs[3]  = '{4'b0001, 4'b0001};
        vecs[4]  = '{4'b0000, 4'b0000};
        vecs[5]  = '{4'b0000, 4'b0000};
        vecs[6]  = '{4'b0110, 4'b0010};
        vecs[7]  = '{4'b0100, 4'b0000};
        vecs[8]  = '{4'b0100, 4'b0100};
        vecs[9]  = '{4'b1101, 4'b0100};
        vecs[10] = '{4'b1001, 4'b0000};
        vecs[11] = '{4'b1001, 4'b1000};
        vecs[12] = '{4'b0001, 4'b0000};
        vecs[13] = '{4'b0000, 4'b0000};
        vecs[14] = '{4'b0001, 4'b0001};
        vecs[15] = '{4'b0000, 4'b0000};
        vecs[16] = '{4'b0000, 4'b0000};

        #12;
        check_out(4'b0000, "reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            cyc(vecs[i].req, vecs[i].exp_grant, $sformatf("vec%0d", i));
        end

        // Asynchronous reset while grant=0010 is active (last owner is 0 here).
        cyc(4'b0010, 4'b0010, "pre_reset_grant");
        #2;
        rst_n = 1'b0;
        #1;
        check_out(4'b0000, "async_reset_mid_grant");
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b0000, 4'b0000, "post_reset_idle0");
        cyc(4'b0000, 4'b0000, "post_reset_idle1");

        // All request: owners 0,1,2,3,0, each held 8 cycles, one-cycle gaps.
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 8; c++) begin
                cyc(4'b1111, 4'(1 << (s % 4)), $sformatf("all_req_o%0d_c%0d", s, c));
            end
            if (s < 4) cyc(4'b1111, 4'b0000, $sformatf("all_req_gap%0d", s));
        end
        cyc(4'b0000, 4'b0000, "all_req_release");
        cyc(4'b0000, 4'b0000, "all_req_idle");

        // Solo hold: no gap when the hold limit expires with nobody waiting.
        for (int c = 0; c < 20; c++) begin
            cyc(4'b0100, 4'b0100, $sformatf("solo_hold_c%0d", c));
        end
        cyc(4'b0000, 4'b0000, "solo_release");
        cyc(4'b0000, 4'b0000, "solo_idle");

        // Fairness: last owner is 2, so req=0011 goes to 0 first.
        cyc(4'b0011, 4'b0001, "fair_o0_c0");
        cyc(4'b0011, 4'b0001, "fair_o0_c1");
        cyc(4'b0010, 4'b0000, "fair_gap0");
        cyc(4'b0010, 4'b0010, "fair_o1_c0");
        cyc(4'b0011, 4'b0010, "fair_o1_c1");
        cyc(4'b0001, 4'b0000, "fair_gap1");
        cyc(4'b0001, 4'b0001, "fair_o0_again");
        cyc(4'b0000, 4'b0000, "fair_release");
        cyc(4'b0000, 4'b0000, "fair_idle");

        // Random traffic: contention and turnaround invariants every cycle.
        prev_g   = grant;
        last_nz  = 4'b0000;
        zero_run = 1;
        for (int c = 0; c < 10000; c++) begin
            req = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            checks++;
            if ($countones(grant) > 1 || busy !== (grant != 4'd0) ||
                owner !== oh2idx(grant) ||
                (grant != 4'd0 && prev_g != 4'd0 && grant != prev_g) ||
                (grant != 4'd0 && last_nz != 4'd0 && grant != last_nz && prev_g == 4'd0 && zero_run < 1)) begin
                errors++;
                $display("FAIL random_invariant cycle %0d: grant=%b prev=%b busy=%b owner=%0d zero_run=%0d, required one-hot or zero, busy==|grant, gap>=1",
                         c, grant, prev_g, busy, owner, zero_run);
            end
            if (grant == 4'd0) begin
                zero_run++;
            end else begin
                if (grant != prev_g) zero_run = 0;
                last_nz = grant;
            end
            prev_g = grant;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
